// File: rtl/deit_csr_pkg.sv
// ----------------------------------------------------------------------------
// deit_csr_pkg
// Shared definitions for the DeiT accelerator CSR block: register word
// indices (byte offset >> 2), configuration field widths, AXI response codes
// and a byte-strobe expansion helper.
// ----------------------------------------------------------------------------
package deit_csr_pkg;

   localparam int AXIL_DATA_W = 32;
   localparam int AXIL_ADDR_W = 6;
   localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

   // Word indices: addr[5:2] of the byte offsets 0x00..0x3C.
   localparam logic [3:0] CSR_CTRL     = 4'h0;  // 0x00
   localparam logic [3:0] CSR_STATUS   = 4'h1;  // 0x04
   localparam logic [3:0] CSR_M_DIM    = 4'h2;  // 0x08
   localparam logic [3:0] CSR_ACC_MODE = 4'h3;  // 0x0C
   localparam logic [3:0] CSR_MULT     = 4'h5;  // 0x14
   localparam logic [3:0] CSR_SHIFT    = 4'h6;  // 0x18
   localparam logic [3:0] CSR_ZP       = 4'h7;  // 0x1C
   localparam logic [3:0] CSR_BIAS     = 4'h8;  // 0x20
   localparam logic [3:0] CSR_OUT_EN   = 4'h9;  // 0x24
   localparam logic [3:0] CSR_VERSION  = 4'hF;  // 0x3C

   localparam int M_DIM_W = 16;
   localparam int MULT_W  = 16;
   localparam int SHIFT_W = 5;
   localparam int ZP_W    = 8;
   localparam int BIAS_W  = 32;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Expand a 4-bit byte strobe into a 32-bit bit mask.
   function automatic logic [AXIL_DATA_W-1:0] strb_to_mask(input logic [AXIL_STRB_W-1:0] strb);
      logic [AXIL_DATA_W-1:0] mask;
      mask = '0;
      for (int b = 0; b < AXIL_STRB_W; b++) begin
         mask[b*8 +: 8] = {8{strb[b]}};
      end
      return mask;
   endfunction

endpackage

// File: rtl/deit_axil_csr_slave_if.sv
// ----------------------------------------------------------------------------
// deit_axil_csr_slave_if
// AXI4-Lite bundle between the PS master and the CSR responder.
//   AW: awaddr, awvalid (M->S), awready (S->M)
//   W : wdata, wstrb, wvalid (M->S), wready (S->M)
//   B : bresp, bvalid (S->M), bready (M->S)
//   AR: araddr, arvalid (M->S), arready (S->M)
//   R : rdata, rresp, rvalid (S->M), rready (M->S)
// ----------------------------------------------------------------------------
interface deit_axil_csr_slave_if;
   import deit_csr_pkg::*;

   logic [AXIL_ADDR_W-1:0] awaddr;
   logic                   awvalid;
   logic                   awready;
   logic [AXIL_DATA_W-1:0] wdata;
   logic [AXIL_STRB_W-1:0] wstrb;
   logic                   wvalid;
   logic                   wready;
   logic [1:0]             bresp;
   logic                   bvalid;
   logic                   bready;
   logic [AXIL_ADDR_W-1:0] araddr;
   logic                   arvalid;
   logic                   arready;
   logic [AXIL_DATA_W-1:0] rdata;
   logic [1:0]             rresp;
   logic                   rvalid;
   logic                   rready;

   modport master (
      output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
      output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
   );

endinterface

// File: rtl/deit_axil_csr_slave.sv
// ----------------------------------------------------------------------------
// deit_axil_csr_slave
// AXI4-Lite responder for the DeiT accelerator control/status registers.
// Ports:
//   clk, rst_n        single clock, synchronous active-low reset
//   s_axi             AXI4-Lite slave modport (AW/W/B/AR/R channels)
//   core_busy_i       core running level
//   core_done_i       one-cycle done pulse, latched into sticky STATUS.done
//   start_pulse_o     one-cycle start to the scheduler
//   m_dim_o, acc_mode_o, ppu_mult_o, ppu_shift_o, ppu_zp_o, ppu_bias_o,
//   out_en_o          configuration fields driven straight from registers
// ----------------------------------------------------------------------------
module deit_axil_csr_slave
   import deit_csr_pkg::*;
#(
   parameter int          C_S_AXI_DATA_WIDTH = 32,
   parameter int          C_S_AXI_ADDR_WIDTH = 6,
   parameter logic [31:0] VERSION_ID         = 32'h0D31_0001
) (
   input  logic                 clk,
   input  logic                 rst_n,
   deit_axil_csr_slave_if.slave s_axi,
   input  logic                 core_busy_i,
   input  logic                 core_done_i,
   output logic                 start_pulse_o,
   output logic [M_DIM_W-1:0]   m_dim_o,
   output logic                 acc_mode_o,
   output logic [MULT_W-1:0]    ppu_mult_o,
   output logic [SHIFT_W-1:0]   ppu_shift_o,
   output logic [ZP_W-1:0]      ppu_zp_o,
   output logic [BIAS_W-1:0]    ppu_bias_o,
   output logic                 out_en_o
);

   // Holding registers keep only the word index; addr[1:0] is ignored.
   logic                            aw_held_q, aw_held_d;
   logic [C_S_AXI_ADDR_WIDTH-1:2]   awaddr_q,  awaddr_d;
   logic                            w_held_q,  w_held_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_q,   wdata_d;
   logic [AXIL_STRB_W-1:0]          wstrb_q,   wstrb_d;
   logic                            bvalid_q,  bvalid_d;
   logic [1:0]                      bresp_q,   bresp_d;
   logic                            rvalid_q,  rvalid_d;
   logic [1:0]                      rresp_q,   rresp_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q,   rdata_d;

   logic                 start_q,  start_d;
   logic                 done_q,   done_d;
   logic [M_DIM_W-1:0]   m_dim_q,  m_dim_d;
   logic                 acc_q,    acc_d;
   logic [MULT_W-1:0]    mult_q,   mult_d;
   logic [SHIFT_W-1:0]   shift_q,  shift_d;
   logic [ZP_W-1:0]      zp_q,     zp_d;
   logic [BIAS_W-1:0]    bias_q,   bias_d;
   logic                 out_en_q, out_en_d;

   logic                          aw_hs, w_hs, ar_hs, commit, done_clr;
   logic [C_S_AXI_DATA_WIDTH-1:0] wr_mask, wr_bits, rd_word;
   logic [1:0]                    rd_resp;

   wire unused_addr_lsbs = &{1'b0, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

   assign s_axi.awready = !aw_held_q && !bvalid_q;
   assign s_axi.wready  = !w_held_q  && !bvalid_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.arready = !rvalid_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rresp   = rresp_q;
   assign s_axi.rdata   = rdata_q;

   assign aw_hs  = s_axi.awvalid && s_axi.awready;
   assign w_hs   = s_axi.wvalid  && s_axi.wready;
   assign ar_hs  = s_axi.arvalid && s_axi.arready;
   // Commit happens on the edge after both halves of the write are held.
   assign commit = aw_held_q && w_held_q;

   assign wr_mask = strb_to_mask(wstrb_q);
   assign wr_bits = wdata_q & wr_mask;

   // ---------------------------------------------------------------- write
   // NOTE: every variable gets a default before any branch, so no path
   // through this block leaves a value unassigned and no latch is inferred.
   always_comb begin
      aw_held_d = aw_held_q;
      awaddr_d  = awaddr_q;
      w_held_d  = w_held_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      start_d   = 1'b0;
      done_clr  = 1'b0;
      m_dim_d   = m_dim_q;
      acc_d     = acc_q;
      mult_d    = mult_q;
      shift_d   = shift_q;
      zp_d      = zp_q;
      bias_d    = bias_q;
      out_en_d  = out_en_q;

      if (aw_hs) begin
         aw_held_d = 1'b1;
         awaddr_d  = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
      end
      if (w_hs) begin
         w_held_d = 1'b1;
         wdata_d  = s_axi.wdata;
         wstrb_d  = s_axi.wstrb;
      end
      if (bvalid_q && s_axi.bready) begin
         bvalid_d = 1'b0;
      end

      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = RESP_OKAY;
         case (awaddr_q)
            CSR_CTRL: begin
               // A start request while the core runs is refused, not queued.
               if (wr_bits[0]) begin
                  if (core_busy_i) bresp_d = RESP_SLVERR;
                  else             start_d = 1'b1;
               end
            end
            CSR_STATUS:   done_clr = wr_bits[1];
            CSR_M_DIM:    m_dim_d  = (m_dim_q  & ~wr_mask[M_DIM_W-1:0]) | wr_bits[M_DIM_W-1:0];
            CSR_ACC_MODE: acc_d    = (acc_q    & ~wr_mask[0])           | wr_bits[0];
            CSR_MULT:     mult_d   = (mult_q   & ~wr_mask[MULT_W-1:0])  | wr_bits[MULT_W-1:0];
            CSR_SHIFT:    shift_d  = (shift_q  & ~wr_mask[SHIFT_W-1:0]) | wr_bits[SHIFT_W-1:0];
            CSR_ZP:       zp_d     = (zp_q     & ~wr_mask[ZP_W-1:0])    | wr_bits[ZP_W-1:0];
            CSR_BIAS:     bias_d   = (bias_q   & ~wr_mask)              | wr_bits;
            CSR_OUT_EN:   out_en_d = (out_en_q & ~wr_mask[0])           | wr_bits[0];
            default:      bresp_d  = RESP_SLVERR;  // unmapped or VERSION (RO)
         endcase
      end

      // A new done pulse outranks a same-cycle W1C.
      done_d = core_done_i || (done_q && !done_clr);
   end

   // ----------------------------------------------------------------- read
   always_comb begin
      rd_word = '0;
      rd_resp = RESP_OKAY;
      case (s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2])
         CSR_CTRL:     rd_word = '0;
         CSR_STATUS:   rd_word = {30'b0, done_q, core_busy_i};
         CSR_M_DIM:    rd_word = {16'b0, m_dim_q};
         CSR_ACC_MODE: rd_word = {31'b0, acc_q};
         CSR_MULT:     rd_word = {16'b0, mult_q};
         CSR_SHIFT:    rd_word = {27'b0, shift_q};
         CSR_ZP:       rd_word = {24'b0, zp_q};
         CSR_BIAS:     rd_word = bias_q;
         CSR_OUT_EN:   rd_word = {31'b0, out_en_q};
         CSR_VERSION:  rd_word = VERSION_ID;
         default:      rd_resp = RESP_SLVERR;
      endcase

      rvalid_d = rvalid_q;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      if (rvalid_q && s_axi.rready) begin
         rvalid_d = 1'b0;
      end
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = rd_resp;
         rdata_d  = rd_word;
      end
   end

   // ------------------------------------------------------------ registers
   // NOTE: state updates use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge; holds, valids and all
      // configuration fields are cleared together so nothing survives it.
      if (!rst_n) begin
         aw_held_q <= 1'b0;
         awaddr_q  <= '0;
         w_held_q  <= 1'b0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         bvalid_q  <= 1'b0;
         bresp_q   <= RESP_OKAY;
         rvalid_q  <= 1'b0;
         rresp_q   <= RESP_OKAY;
         rdata_q   <= '0;
         start_q   <= 1'b0;
         done_q    <= 1'b0;
         m_dim_q   <= '0;
         acc_q     <= 1'b0;
         mult_q    <= '0;
         shift_q   <= '0;
         zp_q      <= '0;
         bias_q    <= '0;
         out_en_q  <= 1'b0;
      end else begin
         aw_held_q <= aw_held_d;
         awaddr_q  <= awaddr_d;
         w_held_q  <= w_held_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         bvalid_q  <= bvalid_d;
         bresp_q   <= bresp_d;
         rvalid_q  <= rvalid_d;
         rresp_q   <= rresp_d;
         rdata_q   <= rdata_d;
         start_q   <= start_d;
         done_q    <= done_d;
         m_dim_q   <= m_dim_d;
         acc_q     <= acc_d;
         mult_q    <= mult_d;
         shift_q   <= shift_d;
         zp_q      <= zp_d;
         bias_q    <= bias_d;
         out_en_q  <= out_en_d;
      end
   end

   assign start_pulse_o = start_q;
   assign m_dim_o       = m_dim_q;
   assign acc_mode_o    = acc_q;
   assign ppu_mult_o    = mult_q;
   assign ppu_shift_o   = shift_q;
   assign ppu_zp_o      = zp_q;
   assign ppu_bias_o    = bias_q;
   assign out_en_o      = out_en_q;

endmodule

// File: tb/tb_deit_axil_csr_slave.sv
// ----------------------------------------------------------------------------
// tb_deit_axil_csr_slave
// Directed bench for the DeiT CSR responder: a vector table of single
// read/write transactions plus hand-timed sequences for write latency,
// split AW/W, B back-pressure, start pulse, sticky done and mid-transaction
// reset. Inputs change 1 time unit after a rising edge; outputs are sampled
// there as well.
// ----------------------------------------------------------------------------
module tb_deit_axil_csr_slave;
   import deit_csr_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   logic core_busy, core_done;
   logic start_pulse, acc_mode, out_en;
   logic [15:0] m_dim, mult;
   logic [4:0]  shift;
   logic [7:0]  zp;
   logic [31:0] bias;

   int n_checks = 0;
   int n_errors = 0;
   int pulse_cnt = 0;

   localparam logic [31:0] VERSION = 32'h0D31_0001;

   deit_axil_csr_slave_if bus ();

   deit_axil_csr_slave dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axi         (bus),
      .core_busy_i   (core_busy),
      .core_done_i   (core_done),
      .start_pulse_o (start_pulse),
      .m_dim_o       (m_dim),
      .acc_mode_o    (acc_mode),
      .ppu_mult_o    (mult),
      .ppu_shift_o   (shift),
      .ppu_zp_o      (zp),
      .ppu_bias_o    (bias),
      .out_en_o      (out_en)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (start_pulse) pulse_cnt <= pulse_cnt + 1;
   end

   typedef struct {
      logic        wr;
      logic [5:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [1:0]  exp_resp;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs [16];

   function automatic vec_t mk(input logic wr, input logic [5:0] a, input logic [31:0] d,
                               input logic [3:0] s, input logic [1:0] r, input logic [31:0] e);
      vec_t v;
      v.wr = wr; v.addr = a; v.data = d; v.strb = s; v.exp_resp = r; v.exp_rdata = e;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ack_b();
      bus.bready = 1'b1;
      tick();
      bus.bready = 1'b0;
   endtask

   // Same-cycle AW+W write; caller is 1 unit after an edge.
   task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int n;
      bus.awaddr = a; bus.awvalid = 1'b1;
      bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
      n = 0;
      while (!(bus.awready && bus.wready) && n < 20) begin tick(); n++; end
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      n = 0;
      while (!bus.bvalid && n < 20) begin tick(); n++; end
      if (!bus.bvalid) check("bvalid_timeout", {31'b0, bus.bvalid}, 32'd1);
      resp = bus.bresp;
      ack_b();
   endtask

   task automatic axi_read(input logic [5:0] a, output logic [31:0] d, output logic [1:0] resp);
      int n;
      bus.araddr = a; bus.arvalid = 1'b1;
      n = 0;
      while (!bus.arready && n < 20) begin tick(); n++; end
      tick();
      bus.arvalid = 1'b0;
      n = 0;
      while (!bus.rvalid && n < 20) begin tick(); n++; end
      if (!bus.rvalid) check("rvalid_timeout", {31'b0, bus.rvalid}, 32'd1);
      d = bus.rdata; resp = bus.rresp;
      bus.rready = 1'b1;
      tick();
      bus.rready = 1'b0;
   endtask

   initial begin
      logic [1:0]  resp;
      logic [31:0] rd;
      int          p0;

      vecs[0]  = mk(0, 6'h3C, 0, 0, RESP_OKAY, VERSION);
      vecs[1]  = mk(0, 6'h08, 0, 0, RESP_OKAY, 0);
      vecs[2]  = mk(1, 6'h08, 32'd32, 4'hF, RESP_OKAY, 0);
      vecs[3]  = mk(0, 6'h08, 0, 0, RESP_OKAY, 32'd32);
      vecs[4]  = mk(1, 6'h14, 32'h1234_ABCD, 4'b0010, RESP_OKAY, 0);
      vecs[5]  = mk(0, 6'h14, 0, 0, RESP_OKAY, 32'h0000_AB00);
      vecs[6]  = mk(1, 6'h30, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR, 0);
      vecs[7]  = mk(0, 6'h30, 0, 0, RESP_SLVERR, 0);
      vecs[8]  = mk(1, 6'h3C, 32'h0, 4'hF, RESP_SLVERR, 0);
      vecs[9]  = mk(0, 6'h3C, 0, 0, RESP_OKAY, VERSION);
      vecs[10] = mk(1, 6'h18, 32'hFFFF_FFFF, 4'hF, RESP_OKAY, 0);
      vecs[11] = mk(0, 6'h18, 0, 0, RESP_OKAY, 32'h1F);
      vecs[12] = mk(1, 6'h1C, 32'h1FF, 4'hF, RESP_OKAY, 0);
      vecs[13] = mk(0, 6'h1C, 0, 0, RESP_OKAY, 32'hFF);
      vecs[14] = mk(1, 6'h0D, 32'h1, 4'hF, RESP_OKAY, 0);   // misaligned -> 0x0C
      vecs[15] = mk(0, 6'h0C, 0, 0, RESP_OKAY, 32'h1);

      rst_n = 1'b0; core_busy = 1'b0; core_done = 1'b0;
      bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
      bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
      bus.rready = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Reset state
      check("rst_ready", {29'b0, bus.awready, bus.wready, bus.arready}, 32'h7);
      check("rst_valid", {30'b0, bus.bvalid, bus.rvalid}, 32'h0);
      check("rst_resp_data", {bus.bresp, bus.rresp, bus.rdata[27:0]}, 32'h0);
      check("rst_cfg", {m_dim, mult}, 32'h0);
      check("rst_cfg2", {bias[23:0], zp}, 32'h0);
      check("rst_cfg3", {25'b0, shift, acc_mode, out_en}, 32'h0);
      check("rst_start", {31'b0, start_pulse}, 32'h0);

      // Table-driven single transactions
      for (int i = 0; i < 16; i++) begin
         if (vecs[i].wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
            check($sformatf("vec%0d_bresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
         end else begin
            axi_read(vecs[i].addr, rd, resp);
            check($sformatf("vec%0d_rresp", i), {30'b0, resp}, {30'b0, vecs[i].exp_resp});
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         end
      end
      check("m_dim_o", {16'b0, m_dim}, 32'd32);
      check("ppu_mult_o", {16'b0, mult}, 32'h0000_AB00);
      check("ppu_shift_o", {27'b0, shift}, 32'h1F);
      check("ppu_zp_o", {24'b0, zp}, 32'hFF);
      check("acc_mode_o", {31'b0, acc_mode}, 32'h1);

      // Write latency: capture edge, then commit edge raises bvalid
      bus.awaddr = 6'h08; bus.awvalid = 1'b1; bus.wdata = 32'h40; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      check("lat_capture_bvalid", {31'b0, bus.bvalid}, 32'h0);
      check("lat_capture_awready", {31'b0, bus.awready}, 32'h0);
      check("lat_capture_m_dim", {16'b0, m_dim}, 32'd32);
      tick();
      check("lat_commit_bvalid", {31'b0, bus.bvalid}, 32'h1);
      check("lat_commit_m_dim", {16'b0, m_dim}, 32'h40);
      ack_b();

      // W first, AW three cycles later; B back-pressure for five cycles
      bus.wdata = 32'hFFFF_FF80; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      tick();
      bus.wvalid = 1'b0;
      check("split_wready_low", {30'b0, bus.wready, bus.awready}, 32'h1);
      repeat (3) tick();
      check("split_no_commit", {31'b0, bus.bvalid}, 32'h0);
      bus.awaddr = 6'h20; bus.awvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      tick();
      check("split_bvalid", {31'b0, bus.bvalid}, 32'h1);
      check("split_bias", bias, 32'hFFFF_FF80);
      check("split_bresp", {30'b0, bus.bresp}, 32'h0);
      for (int c = 0; c < 5; c++) begin
         tick();
         check($sformatf("bp%0d_bvalid_awready", c), {30'b0, bus.bvalid, bus.awready}, 32'h2);
      end
      ack_b();
      check("bp_released", {30'b0, bus.bvalid, bus.awready}, 32'h1);
      check("split_single_commit", bias, 32'hFFFF_FF80);

      // Start pulse, idle and busy
      p0 = pulse_cnt;
      axi_write(6'h00, 32'h1, 4'hF, resp);
      check("start_idle_bresp", {30'b0, resp}, 32'h0);
      check("start_idle_pulses", pulse_cnt - p0, 32'd1);
      core_busy = 1'b1;
      p0 = pulse_cnt;
      axi_write(6'h00, 32'h1, 4'hF, resp);
      check("start_busy_bresp", {30'b0, resp}, {30'b0, RESP_SLVERR});
      check("start_busy_pulses", pulse_cnt - p0, 32'd0);
      axi_read(6'h04, rd, resp);
      check("status_busy", rd, 32'h1);
      core_busy = 1'b0;

      // Sticky done with W1C
      core_done = 1'b1;
      tick();
      core_done = 1'b0;
      axi_read(6'h04, rd, resp);
      check("status_done", rd, 32'h2);
      bus.awaddr = 6'h04; bus.awvalid = 1'b1; bus.wdata = 32'h2; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
      core_done = 1'b1;          // coincides with the commit edge
      tick();
      core_done = 1'b0;
      check("w1c_race_bvalid", {31'b0, bus.bvalid}, 32'h1);
      ack_b();
      axi_read(6'h04, rd, resp);
      check("status_set_wins", rd, 32'h2);
      axi_write(6'h04, 32'h2, 4'hF, resp);
      axi_read(6'h04, rd, resp);
      check("status_cleared", rd, 32'h0);

      // Reset with W held: the held beat must be discarded
      bus.wdata = 32'h77; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      tick();
      bus.wvalid = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mid_rst_ready", {30'b0, bus.wready, bus.awready}, 32'h3);
      check("mid_rst_cfg", {m_dim, 15'b0, out_en}, 32'h0);
      check("mid_rst_bias", bias, 32'h0);
      bus.awaddr = 6'h08; bus.awvalid = 1'b1;
      tick();
      bus.awvalid = 1'b0;
      repeat (3) tick();
      check("mid_rst_w_discarded", {31'b0, bus.bvalid}, 32'h0);
      bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
      tick();
      bus.wvalid = 1'b0;
      tick();
      check("post_rst_commit", {15'b0, bus.bvalid, m_dim}, 32'h0001_0055);
      ack_b();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
